// File: rtl/tt_spine_sel_if.sv
// Bus bundle between the spine selector and its controller.
//
// Handshake: a direct load transfers on a rising clock edge where both
// load_vld and load_rdy are 1. load_vld may be raised at any time and
// load_idx must be stable while load_vld is high. load_rdy does not depend
// combinationally on load_vld. A transferred load is always consumed, even
// if it is later dropped by priority or rejected as out of range.
//
// dbg_state encoding: 0 IDLE, 1 ACTIVE, 2 DRAIN, 3 SETTLE.
`timescale 1ns/1ps
interface tt_spine_sel_if;
  logic       sel_rst;
  logic       sel_inc;
  logic       ena_req;
  logic       load_vld;
  logic [9:0] load_idx;
  logic       load_rdy;
  logic       load_err;
  logic [9:0] spine_sel;
  logic       spine_ena;
  logic [9:0] cur_idx;
  logic       busy;
  logic [1:0] dbg_state;

  // Selector side.
  modport slave (
    input  sel_rst, sel_inc, ena_req, load_vld, load_idx,
    output load_rdy, load_err, spine_sel, spine_ena, cur_idx, busy, dbg_state
  );

  // Controller side.
  modport master (
    output sel_rst, sel_inc, ena_req, load_vld, load_idx,
    input  load_rdy, load_err, spine_sel, spine_ena, cur_idx, busy, dbg_state
  );
endinterface

// File: rtl/tt_spine_sel.sv
// Spine selector: chooses one user design on the shared spine and gates its
// enable so the select field never moves while a design is enabled. Index
// changes from ACTIVE first drop the enable for one cycle (DRAIN), then move
// the select and wait SETTLE cycles before re-enabling.
`timescale 1ns/1ps
module tt_spine_sel #(
  parameter int N_UM   = 16,
  parameter int N_MUX  = 16,
  parameter int SETTLE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  tt_spine_sel_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

  localparam logic [4:0] UM_LAST  = 5'(N_UM - 1);
  localparam logic [4:0] MUX_LAST = 5'(N_MUX - 1);
  localparam logic [5:0] UM_LIM   = 6'(N_UM);
  localparam logic [5:0] MUX_LIM  = 6'(N_MUX);
  localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [9:0] idx_q, idx_d;
  logic [9:0] pend_q, pend_d;
  logic [9:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ena_q, ena_d;
  logic       busy_q, busy_d;
  logic       rdy_q, rdy_d;
  logic       err_q, err_d;

  logic       load_acc;
  logic       load_ok;
  logic       req_chg;
  logic       req_bad;
  logic [9:0] req_tgt;
  logic [9:0] drain_tgt;

  // Index {m, u} to the interleaved select field used by the tt_mux array.
  function automatic logic [9:0] map_sel(input logic [9:0] idx);
    return {idx[9:6], idx[0], idx[5], idx[4:1]};
  endfunction

  // Next design in scan order, wrapping at the last user module of the last mux.
  function automatic logic [9:0] next_idx(input logic [9:0] idx);
    logic [4:0] m;
    logic [4:0] u;
    m = idx[9:5];
    u = idx[4:0];
    if (u == UM_LAST) begin
      u = 5'd0;
      m = (m == MUX_LAST) ? 5'd0 : m + 5'd1;
    end else begin
      u = u + 5'd1;
    end
    return {m, u};
  endfunction

  // Request decode with priority sel_rst > accepted load > sel_inc.
  always_comb begin
    req_chg  = 1'b0;
    req_bad  = 1'b0;
    req_tgt  = idx_q;
    load_acc = bus.load_vld & rdy_q;
    load_ok  = ({1'b0, bus.load_idx[4:0]} < UM_LIM) &&
               ({1'b0, bus.load_idx[9:5]} < MUX_LIM);
    if (bus.sel_rst) begin
      req_chg = 1'b1;
      req_tgt = 10'd0;
    end else if (load_acc && load_ok) begin
      req_chg = 1'b1;
      req_tgt = bus.load_idx;
    end else if (load_acc) begin
      req_bad = 1'b1;
    end else if (bus.sel_inc) begin
      req_chg = 1'b1;
      req_tgt = next_idx(idx_q);
    end
  end

  // A reset request arriving during DRAIN overrides the pending index.
  always_comb begin
    drain_tgt = bus.sel_rst ? 10'd0 : pend_q;
  end

  // Next-state and next-output logic for the selection FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_chg) begin
          // Nothing is enabled, so the select may move on the next edge.
          idx_d   = req_tgt;
          sel_d   = map_sel(req_tgt);
          cnt_d   = CNT_INIT;
          state_d = ST_SETTLE;
        end else if (req_bad) begin
          err_d = 1'b1;
        end else if (bus.ena_req) begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (req_chg) begin
          // Drop the enable first; the select moves one edge later.
          pend_d  = req_tgt;
          state_d = ST_DRAIN;
        end else if (req_bad) begin
          err_d = 1'b1;
        end else if (!bus.ena_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        idx_d   = drain_tgt;
        sel_d   = map_sel(drain_tgt);
        cnt_d   = CNT_INIT;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (bus.sel_rst) begin
          idx_d = 10'd0;
          sel_d = 10'd0;
          cnt_d = CNT_INIT;
        end else if (cnt_q == 4'd0) begin
          state_d = bus.ena_req ? ST_ACTIVE : ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they come straight from flops.
  always_comb begin
    ena_d  = (state_d == ST_ACTIVE);
    busy_d = (state_d == ST_DRAIN) || (state_d == ST_SETTLE);
    rdy_d  = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);
  end

  // State and output registers; reset clears everything including load_rdy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 10'd0;
      pend_q  <= 10'd0;
      sel_q   <= 10'd0;
      cnt_q   <= 4'd0;
      ena_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      ena_q   <= ena_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign bus.spine_sel = sel_q;
  assign bus.spine_ena = ena_q;
  assign bus.cur_idx   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.load_rdy  = rdy_q;
  assign bus.load_err  = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tt_spine_sel.sv
// Bench for tt_spine_sel with N_UM=16, N_MUX=16, SETTLE=4. Inputs change and
// outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_tt_spine_sel;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tt_spine_sel_if bus();

  tt_spine_sel #(.N_UM(16), .N_MUX(16), .SETTLE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [1:0] S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DRAIN = 2'd2, S_SETTLE = 2'd3;

  int checks = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    string      name;
    logic       rst;
    logic       inc;
    logic       ld;
    logic [9:0] lidx;
    logic [9:0] exp_idx;
    logic [9:0] exp_sel;
    logic       exp_err;
    logic       exp_chg;
  } vec_t;

  vec_t vecs[10];

  // ---------------- reference helpers ----------------
  function automatic logic [9:0] ref_sel(input logic [9:0] idx);
    logic [4:0] m;
    logic [4:0] u;
    logic [9:0] s;
    m = idx[9:5];
    u = idx[4:0];
    s[9:6] = m[4:1];
    s[5]   = u[0];
    s[4]   = m[0];
    s[3:0] = u[4:1];
    return s;
  endfunction

  function automatic logic [9:0] ref_inc(input logic [9:0] idx);
    int m;
    int u;
    m = int'(idx[9:5]);
    u = int'(idx[4:0]) + 1;
    if (u == 16) begin
      u = 0;
      m = m + 1;
      if (m == 16) m = 0;
    end
    return {5'(m), 5'(u)};
  endfunction

  function automatic vec_t mk(input string n, input logic r, input logic i, input logic l,
                              input logic [9:0] li, input logic [9:0] ei, input logic [9:0] es,
                              input logic ee, input logic ec);
    vec_t v;
    v.name = n; v.rst = r; v.inc = i; v.ld = l; v.lidx = li;
    v.exp_idx = ei; v.exp_sel = es; v.exp_err = ee; v.exp_chg = ec;
    return v;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic rst, input logic inc, input logic ld, input logic [9:0] lidx);
    bus.sel_rst  = rst;
    bus.sel_inc  = inc;
    bus.load_vld = ld;
    bus.load_idx = lidx;
    @(negedge clk);
    bus.sel_rst  = 1'b0;
    bus.sel_inc  = 1'b0;
    bus.load_vld = 1'b0;
    bus.load_idx = 10'd0;
  endtask

  // Counts samples with spine_ena low until it rises, bounded.
  task automatic wait_ena(input string name, output int lows);
    lows = 0;
    while (bus.spine_ena !== 1'b1 && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    chk({name, "_ena_bound"}, {31'd0, bus.spine_ena}, 32'd1);
  endtask

  task automatic pop_check(input string name);
    logic [9:0] e;
    if (exp_q.size() == 0) begin
      chk({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({name, "_cur_idx"}, {22'd0, bus.cur_idx}, {22'd0, e});
      chk({name, "_spine_sel"}, {22'd0, bus.spine_sel}, {22'd0, ref_sel(e)});
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cur_idx"}, {22'd0, bus.cur_idx}, 32'd0);
    chk({name, "_spine_sel"}, {22'd0, bus.spine_sel}, 32'd0);
    chk({name, "_ena"}, {31'd0, bus.spine_ena}, 32'd0);
    chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({name, "_rdy"}, {31'd0, bus.load_rdy}, 32'd0);
    chk({name, "_err"}, {31'd0, bus.load_err}, 32'd0);
    chk({name, "_state"}, {30'd0, bus.dbg_state}, {30'd0, S_IDLE});
  endtask

  // ---------------- select stability monitor ----------------
  logic [9:0] prev_sel;
  logic       prev_ena;
  logic       mon_arm = 1'b0;
  int         mon_viol = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && mon_arm) begin
      if (bus.spine_sel !== prev_sel && (prev_ena === 1'b1 || bus.spine_ena === 1'b1)) begin
        mon_viol++;
        $display("FAIL sel_stable_monitor: sel %0h -> %0h with ena %b -> %b",
                 prev_sel, bus.spine_sel, prev_ena, bus.spine_ena);
      end
    end
    prev_sel = bus.spine_sel;
    prev_ena = bus.spine_ena;
    mon_arm  = (rst_n === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  int         lows;
  int         busy_n;
  logic [9:0] model_idx;
  logic [9:0] nxt;
  logic [9:0] sel_before;
  logic [4:0] rm;
  logic [4:0] ru;

  initial begin
    vecs[0] = mk("ld_2_15",   0, 0, 1, {5'd2, 5'd15},  {5'd2, 5'd15},  10'b0001_1_0_0111, 0, 1);
    vecs[1] = mk("inc_to_3_0", 0, 1, 0, 10'd0,         {5'd3, 5'd0},   10'b0001_0_1_0000, 0, 1);
    vecs[2] = mk("ld_15_15",  0, 0, 1, {5'd15, 5'd15}, {5'd15, 5'd15}, 10'b0111_1_1_0111, 0, 1);
    vecs[3] = mk("inc_wrap",  0, 1, 0, 10'd0,          {5'd0, 5'd0},   10'b0000_0_0_0000, 0, 1);
    vecs[4] = mk("ld_u20_bad", 0, 0, 1, {5'd1, 5'd20}, {5'd0, 5'd0},   10'b0000_0_0_0000, 1, 0);
    vecs[5] = mk("ld_m16_bad", 0, 0, 1, {5'd16, 5'd0}, {5'd0, 5'd0},   10'b0000_0_0_0000, 1, 0);
    vecs[6] = mk("ld_same",   0, 0, 1, {5'd0, 5'd0},   {5'd0, 5'd0},   10'b0000_0_0_0000, 0, 1);
    vecs[7] = mk("ld_5_6",    0, 0, 1, {5'd5, 5'd6},   {5'd5, 5'd6},   10'b0010_0_1_0011, 0, 1);
    vecs[8] = mk("inc_5_7",   0, 1, 0, 10'd0,          {5'd5, 5'd7},   10'b0010_1_1_0011, 0, 1);
    vecs[9] = mk("rst_ld_inc", 1, 1, 1, {5'd7, 5'd7},  {5'd0, 5'd0},   10'b0000_0_0_0000, 0, 1);

    bus.sel_rst = 0; bus.sel_inc = 0; bus.ena_req = 0; bus.load_vld = 0; bus.load_idx = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");

    rst_n = 1'b1;
    @(negedge clk);
    chk("release_rdy", {31'd0, bus.load_rdy}, 32'd1);
    chk("release_ena", {31'd0, bus.spine_ena}, 32'd0);

    bus.ena_req = 1'b1;
    @(negedge clk);
    chk("ena_rise", {31'd0, bus.spine_ena}, 32'd1);
    chk("ena_rise_state", {30'd0, bus.dbg_state}, {30'd0, S_ACTIVE});

    // Three increments spaced ten cycles apart.
    model_idx = 10'd0;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back(10'(k));
      pulse(0, 1, 0, 10'd0);
      chk("inc_drain_state", {30'd0, bus.dbg_state}, {30'd0, S_DRAIN});
      chk("inc_drain_idx", {22'd0, bus.cur_idx}, 32'(k - 1));
      chk("inc_drain_sel", {22'd0, bus.spine_sel}, {22'd0, ref_sel(10'(k - 1))});
      @(negedge clk);
      chk("inc_settle_state", {30'd0, bus.dbg_state}, {30'd0, S_SETTLE});
      wait_ena("inc_seq", lows);
      chk("inc_low_cycles", 32'(lows + 1), 32'd5);
      pop_check("inc_seq");
      repeat (4) @(negedge clk);
    end
    model_idx = 10'd3;

    // Table of single-cycle requests from ACTIVE.
    foreach (vecs[i]) begin
      if (vecs[i].ld) chk({vecs[i].name, "_rdy"}, {31'd0, bus.load_rdy}, 32'd1);
      sel_before = bus.spine_sel;
      exp_q.push_back(vecs[i].exp_idx);
      pulse(vecs[i].rst, vecs[i].inc, vecs[i].ld, vecs[i].lidx);
      chk({vecs[i].name, "_err"}, {31'd0, bus.load_err}, {31'd0, vecs[i].exp_err});
      chk({vecs[i].name, "_busy"}, {31'd0, bus.busy}, {31'd0, vecs[i].exp_chg});
      chk({vecs[i].name, "_sel_held"}, {22'd0, bus.spine_sel}, {22'd0, sel_before});
      wait_ena(vecs[i].name, lows);
      chk({vecs[i].name, "_lows"}, 32'(lows), vecs[i].exp_chg ? 32'd5 : 32'd0);
      @(negedge clk);
      chk({vecs[i].name, "_err_clear"}, {31'd0, bus.load_err}, 32'd0);
      chk({vecs[i].name, "_tbl_sel"}, {22'd0, bus.spine_sel}, {22'd0, vecs[i].exp_sel});
      pop_check(vecs[i].name);
      model_idx = vecs[i].exp_idx;
    end

    // Random valid loads and increments.
    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 1) == 1) begin
        nxt = ref_inc(model_idx);
        exp_q.push_back(nxt);
        pulse(0, 1, 0, 10'd0);
      end else begin
        rm = 5'($urandom_range(0, 15));
        ru = 5'($urandom_range(0, 15));
        nxt = {rm, ru};
        exp_q.push_back(nxt);
        pulse(0, 0, 1, nxt);
      end
      wait_ena("rand", lows);
      chk("rand_lows", 32'(lows), 32'd5);
      pop_check("rand");
      model_idx = nxt;
    end

    // sel_inc while settling is ignored.
    nxt = ref_inc(model_idx);
    exp_q.push_back(nxt);
    pulse(0, 1, 0, 10'd0);
    repeat (2) @(negedge clk);
    chk("busy_inc_state", {30'd0, bus.dbg_state}, {30'd0, S_SETTLE});
    pulse(0, 1, 0, 10'd0);
    wait_ena("busy_inc", lows);
    chk("busy_inc_lows", 32'(lows), 32'd2);
    pop_check("busy_inc");
    model_idx = nxt;

    // sel_rst while settling restarts the settle at index 0.
    pulse(0, 1, 0, 10'd0);
    repeat (2) @(negedge clk);
    exp_q.push_back(10'd0);
    pulse(1, 0, 0, 10'd0);
    chk("busy_rst_idx", {22'd0, bus.cur_idx}, 32'd0);
    chk("busy_rst_busy", {31'd0, bus.busy}, 32'd1);
    wait_ena("busy_rst", lows);
    chk("busy_rst_lows", 32'(lows), 32'd4);
    pop_check("busy_rst");
    model_idx = 10'd0;

    // Drop to IDLE, change there (no DRAIN), re-enable.
    bus.ena_req = 1'b0;
    @(negedge clk);
    chk("ena_fall", {31'd0, bus.spine_ena}, 32'd0);
    chk("ena_fall_state", {30'd0, bus.dbg_state}, {30'd0, S_IDLE});
    pulse(0, 1, 0, 10'd0);
    chk("idle_inc_idx", {22'd0, bus.cur_idx}, 32'd1);
    chk("idle_inc_state", {30'd0, bus.dbg_state}, {30'd0, S_SETTLE});
    busy_n = 0;
    while (bus.busy === 1'b1 && busy_n < 40) begin
      busy_n++;
      @(negedge clk);
    end
    chk("idle_settle_cycles", 32'(busy_n), 32'd4);
    chk("idle_return_state", {30'd0, bus.dbg_state}, {30'd0, S_IDLE});
    chk("idle_return_ena", {31'd0, bus.spine_ena}, 32'd0);
    bus.ena_req = 1'b1;
    @(negedge clk);
    chk("idle_reenable", {31'd0, bus.spine_ena}, 32'd1);

    // Asynchronous reset in the middle of SETTLE.
    pulse(0, 1, 0, 10'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    bus.ena_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {31'd0, bus.load_rdy}, 32'd1);
    repeat (5) @(negedge clk);
    chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_rst_idx", {22'd0, bus.cur_idx}, 32'd0);
    chk("post_rst_state", {30'd0, bus.dbg_state}, {30'd0, S_IDLE});

    chk("sel_stable_monitor", 32'(mon_viol), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
